// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone classic arbiter in front of one single-port memory.
// Round-robin grant on ties, grant held for the whole master cycle (cyc high),
// handoff to a waiting master without a dead cycle. The slave bus is a
// combinational mux selected by the registered grant state.
// Optional watchdog: define ARB_TIMEOUT_EN to abort a granted access whose
// strobe goes unacknowledged for TIMEOUT_CYCLES cycles (m*_err_o pulse).
module wb_mem_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] m0_adr_i,
    input  logic [DATA_WIDTH-1:0] m0_dat_i,
    input  logic                  m0_we_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_cyc_i,
    output logic [DATA_WIDTH-1:0] m0_dat_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    input  logic [ADDR_WIDTH-1:0] m1_adr_i,
    input  logic [DATA_WIDTH-1:0] m1_dat_i,
    input  logic                  m1_we_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_cyc_i,
    output logic [DATA_WIDTH-1:0] m1_dat_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic [ADDR_WIDTH-1:0] s_adr_o,
    output logic [DATA_WIDTH-1:0] s_dat_o,
    output logic                  s_we_o,
    output logic                  s_stb_o,
    output logic                  s_cyc_o,
    input  logic [DATA_WIDTH-1:0] s_dat_i,
    input  logic                  s_ack_i,
    output logic [1:0]            gnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t     state;
    state_t     nxt;
    logic       last_gnt;
    logic [1:0] gnt_q;
    logic       sel0;
    logic       sel1;
    logic       timeout;

    // Next grant: ties go to the master not served last; a releasing master
    // hands straight over to a waiting one; a watchdog abort returns to IDLE.
    function automatic state_t arb_next(input state_t cur, input logic c0,
                                        input logic c1, input logic last,
                                        input logic tmo);
        state_t n;
        n = cur;
        case (cur)
            IDLE: begin
                if (c0 && (!c1 || last)) n = GNT0;
                else if (c1)             n = GNT1;
            end
            GNT0: begin
                if (tmo)      n = IDLE;
                else if (!c0) n = c1 ? GNT1 : IDLE;
            end
            GNT1: begin
                if (tmo)      n = IDLE;
                else if (!c1) n = c0 ? GNT0 : IDLE;
            end
            default: n = IDLE;
        endcase
        return n;
    endfunction

    // One-hot {m1,m0} grant encoding of a state.
    function automatic logic [1:0] gnt_of(input state_t s);
        return {s == GNT1, s == GNT0};
    endfunction

    assign nxt  = arb_next(state, m0_cyc_i, m1_cyc_i, last_gnt, timeout);
    assign sel0 = (state == GNT0);
    assign sel1 = (state == GNT1);

    // Grant FSM: state, registered grant output and last-served master.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt_q    <= 2'b00;
            last_gnt <= 1'b1;
        end else begin
            state <= nxt;
            gnt_q <= gnt_of(nxt);
            if (sel0 && nxt != GNT0)
                last_gnt <= 1'b0;
            else if (sel1 && nxt != GNT1)
                last_gnt <= 1'b1;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] tmo_cnt;

    assign timeout = (state != IDLE) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES));

    // Watchdog: counts unacknowledged strobe cycles of the current grant.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE || nxt != state || s_ack_i)
            tmo_cnt <= '0;
        else if (s_stb_o)
            tmo_cnt <= tmo_cnt + CNT_W'(1);
    end

    assign m0_err_o = sel0 & timeout;
    assign m1_err_o = sel1 & timeout;
`else
    // Watchdog compiled out: the limit can never be reached.
    assign timeout  = (TIMEOUT_CYCLES < 0);
    assign m0_err_o = 1'b0;
    assign m1_err_o = 1'b0;
`endif

    // Slave side follows the granted master; nothing is driven while idle
    // or in the cycle a watchdog abort is signalled.
    assign s_adr_o = sel1 ? m1_adr_i : (sel0 ? m0_adr_i : '0);
    assign s_dat_o = sel1 ? m1_dat_i : (sel0 ? m0_dat_i : '0);
    assign s_we_o  = (sel0 & m0_we_i) | (sel1 & m1_we_i);
    assign s_cyc_o = ((sel0 & m0_cyc_i) | (sel1 & m1_cyc_i)) & ~timeout;
    assign s_stb_o = ((sel0 & m0_cyc_i & m0_stb_i) |
                      (sel1 & m1_cyc_i & m1_stb_i)) & ~timeout;

    // Only the granted master sees the slave response.
    assign m0_ack_o = sel0 & s_ack_i & ~timeout;
    assign m1_ack_o = sel1 & s_ack_i & ~timeout;
    assign m0_dat_o = sel0 ? s_dat_i : '0;
    assign m1_dat_o = sel1 ? s_dat_i : '0;

    assign gnt_o = gnt_q;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter with a one-cycle-ack memory model.
// The watchdog step only runs when ARB_TIMEOUT_EN is defined.
module tb_wb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic [7:0]  m0_adr, m1_adr, s_adr;
    logic [31:0] m0_wdat, m1_wdat, m0_rdat, m1_rdat, s_wdat, s_rdat;
    logic        m0_we, m0_stb, m0_cyc, m0_ack, m0_err;
    logic        m1_we, m1_stb, m1_cyc, m1_ack, m1_err;
    logic        s_we, s_stb, s_cyc, s_ack;
    logic [1:0]  gnt;

    int checks = 0;
    int errors = 0;

    // Memory model: registered ack one cycle after cyc&stb, combinational read.
    logic [31:0] mem [256] = '{5: 32'h0000_0033, default: 32'h0};
    logic        mem_noack = 1'b0;

    wb_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_we_i(m0_we),
        .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc),
        .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_we_i(m1_we),
        .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc),
        .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_we_o(s_we),
        .s_stb_o(s_stb), .s_cyc_o(s_cyc),
        .s_dat_i(s_rdat), .s_ack_i(s_ack),
        .gnt_o(gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign s_rdat = mem[s_adr];

    always @(posedge clk) begin
        if (rst) begin
            s_ack <= 1'b0;
        end else begin
            s_ack <= s_cyc && s_stb && !s_ack && !mem_noack;
            if (s_cyc && s_stb && !s_ack && !mem_noack && s_we)
                mem[s_adr] <= s_wdat;
        end
    end

    // Both masters must never be acknowledged in the same cycle.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            assert (!(m0_ack && m1_ack)) else begin
                errors++;
                $error("FAIL both_ack observed m0_ack=%0b m1_ack=%0b expected not both", m0_ack, m1_ack);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_set(input int idx, input logic cyc, input logic stb, input logic we,
                         input logic [7:0] adr, input logic [31:0] dat);
        if (idx == 0) begin
            m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_adr = adr; m0_wdat = dat;
        end else begin
            m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_adr = adr; m1_wdat = dat;
        end
    endtask

    function automatic logic ack_of(input int idx);
        return (idx == 0) ? m0_ack : m1_ack;
    endfunction

    function automatic logic [31:0] dat_of(input int idx);
        return (idx == 0) ? m0_rdat : m1_rdat;
    endfunction

    function automatic logic [1:0] onehot(input int idx);
        return (idx == 0) ? 2'b01 : 2'b10;
    endfunction

    // Advance until master idx is acknowledged, at most 8 cycles.
    task automatic wait_ack(input int idx, input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!ack_of(idx) && n < 8);
        check(tag, ack_of(idx), 1);
    endtask

    // Both masters read adr 5 together; first must be the winner, the other
    // is handed the bus on the edge the winner drops cyc.
    task automatic tie_round(input int first, input string tag);
        int second;
        second = 1 - first;
        m_set(0, 1, 1, 0, 8'h05, 0);
        m_set(1, 1, 1, 0, 8'h05, 0);
        tick();
        check({tag, "_gnt_first"}, gnt, onehot(first));
        wait_ack(first, {tag, "_ack_first"});
        check({tag, "_dat_first"}, dat_of(first), 32'h33);
        m_set(first, 0, 0, 0, 0, 0);
        tick();
        check({tag, "_gnt_second"}, gnt, onehot(second));
        wait_ack(second, {tag, "_ack_second"});
        check({tag, "_dat_second"}, dat_of(second), 32'h33);
        m_set(second, 0, 0, 0, 0, 0);
        tick();
        check({tag, "_gnt_idle"}, gnt, 2'b00);
    endtask

    initial begin
        rst = 1'b1;
        m_set(0, 0, 0, 0, 0, 0);
        m_set(1, 0, 0, 0, 0, 0);
        repeat (3) tick();

        // Reset state
        check("rst_gnt", gnt, 2'b00);
        check("rst_s_cyc", s_cyc, 0);
        check("rst_s_stb", s_stb, 0);
        check("rst_acks", {m0_ack, m1_ack}, 2'b00);
        check("rst_errs", {m0_err, m1_err}, 2'b00);
        check("rst_dats", {m0_rdat, m1_rdat}, 64'h0);
        rst = 1'b0;
        tick();

        // Single read of adr 5 by M0
        m_set(0, 1, 1, 0, 8'h05, 0);
        tick();
        check("rd_gnt", gnt, 2'b01);
        check("rd_s_stb", s_stb, 1);
        check("rd_s_adr", s_adr, 8'h05);
        check("rd_ack_early", m0_ack, 0);
        tick();
        check("rd_ack", m0_ack, 1);
        check("rd_dat", m0_rdat, 32'h33);
        check("rd_m1_ack", m1_ack, 0);
        m_set(0, 0, 0, 0, 0, 0);
        tick();
        check("rd_idle_gnt", gnt, 2'b00);
        check("rd_idle_cyc", s_cyc, 0);

        // Ties from reset, three rounds, then a tie after M0 was served last
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tie_round(0, "tie1");
        tie_round(0, "tie2");
        tie_round(0, "tie3");
        m_set(0, 1, 1, 0, 8'h05, 0);
        tick();
        wait_ack(0, "solo_ack");
        m_set(0, 0, 0, 0, 0, 0);
        tick();
        tie_round(1, "tie4");

        // Handoff: M1 waits while M0 writes 0x10
        m_set(0, 1, 1, 1, 8'h10, 32'hCAFE_F00D);
        tick();
        check("ho_gnt0", gnt, 2'b01);
        m_set(1, 1, 1, 0, 8'h10, 0);
        tick();
        check("ho_m0_ack", m0_ack, 1);
        check("ho_m1_held_ack", m1_ack, 0);
        check("ho_m1_held_dat", m1_rdat, 32'h0);
        m_set(0, 0, 0, 0, 0, 0);
        tick();
        check("ho_gnt1", gnt, 2'b10);
        check("ho_m1_ack_early", m1_ack, 0);
        tick();
        check("ho_m1_ack", m1_ack, 1);
        check("ho_m1_dat", m1_rdat, 32'hCAFE_F00D);
        m_set(1, 0, 0, 0, 0, 0);
        tick();
        check("ho_idle", gnt, 2'b00);

        // Burst: M0 writes adr 0..3 with 1..4 under one cyc, M1 waits
        m_set(0, 1, 1, 1, 8'h00, 32'd1);
        tick();
        check("bu_gnt", gnt, 2'b01);
        wait_ack(0, "bu_ack0");
        m_set(1, 1, 1, 0, 8'h00, 0);
        for (int i = 1; i < 4; i++) begin
            m_set(0, 1, 1, 1, 8'(i), 32'(i + 1));
            wait_ack(0, "bu_ack");
            check("bu_gnt_held", gnt, 2'b01);
            check("bu_m1_ack", m1_ack, 0);
        end
        m_set(0, 0, 0, 0, 0, 0);
        tick();
        check("bu_gnt1", gnt, 2'b10);
        for (int i = 0; i < 4; i++) begin
            m_set(1, 1, 1, 0, 8'(i), 0);
            wait_ack(1, "bu_rd_ack");
            check("bu_rd_dat", m1_rdat, 32'(i + 1));
        end
        m_set(1, 0, 0, 0, 0, 0);
        tick();
        check("bu_idle", gnt, 2'b00);

        // Reset while M1 holds the grant with a write pending
        m_set(1, 1, 1, 1, 8'h20, 32'hDEAD_BEEF);
        tick();
        check("rm_gnt1", gnt, 2'b10);
        check("rm_s_cyc_before", s_cyc, 1);
        rst = 1'b1;
        tick();
        check("rm_gnt", gnt, 2'b00);
        check("rm_s_cyc", s_cyc, 0);
        check("rm_acks", {m0_ack, m1_ack}, 2'b00);
        rst = 1'b0;
        m_set(1, 0, 0, 0, 0, 0);
        tick();
        tie_round(0, "rm_tie");

`ifdef ARB_TIMEOUT_EN
        // Watchdog: M1 read never acknowledged, M0 waiting
        begin
            int errsum;
            errsum = 0;
            mem_noack = 1'b1;
            m_set(1, 1, 1, 0, 8'h30, 0);
            tick();
            check("to_gnt1", gnt, 2'b10);
            check("to_s_stb", s_stb, 1);
            m_set(0, 1, 1, 0, 8'h05, 0);
            for (int i = 0; i < 15; i++) begin
                tick();
                errsum += int'(m0_err) + int'(m1_err);
            end
            check("to_no_early_err", errsum, 0);
            tick();
            check("to_m1_err", m1_err, 1);
            check("to_m1_ack", m1_ack, 0);
            check("to_m0_err", m0_err, 0);
            check("to_s_cyc_abort", s_cyc, 0);
            m_set(1, 0, 0, 0, 0, 0);
            tick();
            check("to_err_pulse", m1_err, 0);
            check("to_s_cyc_idle", s_cyc, 0);
            check("to_gnt_idle", gnt, 2'b00);
            mem_noack = 1'b0;
            tick();
            check("to_gnt0", gnt, 2'b01);
            wait_ack(0, "to_m0_ack");
            check("to_m0_dat", m0_rdat, 32'h33);
            m_set(0, 0, 0, 0, 0, 0);
            tick();
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
